// File: rtl/frog_input_sequencer_pkg.sv
// Shared constants for the frog input sequencer: direction codes, default
// auto-repeat timing, FSM state encoding and a small sizing helper.
package frog_input_sequencer_pkg;

  localparam int unsigned C_REPEAT_DELAY_DEFAULT  = 12_500_000;
  localparam int unsigned C_REPEAT_PERIOD_DEFAULT = 5_000_000;

  localparam logic [1:0] C_DIR_UP = 2'd0;
  localparam logic [1:0] C_DIR_LT = 2'd1;
  localparam logic [1:0] C_DIR_RT = 2'd2;
  localparam logic [1:0] C_DIR_DN = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT,
    ST_ALL_HELD,
    ST_WAIT_RELEASE
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frog_dir_priority.sv
// Combinational switch decoder: Up > Left > Right > Down priority direction,
// plus any-pressed and all-pressed flags.
module frog_dir_priority
  import frog_input_sequencer_pkg::*;
(
  input  logic [3:0] switches_i,
  output logic [1:0] dir_o,
  output logic       any_o,
  output logic       all_o
);

  // Priority encode the held switches; bit 0 is Up, bit 3 is Down.
  always_comb begin
    dir_o = C_DIR_DN;
    if (switches_i[0])      dir_o = C_DIR_UP;
    else if (switches_i[1]) dir_o = C_DIR_LT;
    else if (switches_i[2]) dir_o = C_DIR_RT;
    any_o = |switches_i;
    all_o = &switches_i;
  end

endmodule

// File: rtl/frog_input_sequencer.sv
// Converts debounced switch levels into one-cycle move/start pulses with
// auto-repeat while a switch is held, and keeps the sprite facing direction.
module frog_input_sequencer
  import frog_input_sequencer_pkg::*;
#(
  parameter int unsigned C_REPEAT_DELAY  = C_REPEAT_DELAY_DEFAULT,
  parameter int unsigned C_REPEAT_PERIOD = C_REPEAT_PERIOD_DEFAULT
)(
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  input  logic       i_Game_Active,
  output logic       o_Move_Valid,
  output logic [1:0] o_Move_Dir,
  output logic       o_Start,
  output logic [1:0] o_Frog_Direction
);

  localparam int unsigned CNT_W = $clog2(max_u(C_REPEAT_DELAY, C_REPEAT_PERIOD));
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(C_REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(C_REPEAT_PERIOD - 1);

  logic [1:0] w_Dir;
  logic       w_Any;
  logic       w_All;

  frog_dir_priority u_dir_priority (
    .switches_i ({i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1}),
    .dir_o      (w_Dir),
    .any_o      (w_Any),
    .all_o      (w_All)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             move_valid_q, move_valid_d;
  logic             start_q, start_d;
  logic [1:0]       move_dir_q, move_dir_d;
  logic [1:0]       frog_dir_q, frog_dir_d;
  logic             block_q, block_d;
  logic             move_req;

  // A reset taken while a switch is held leaves IDLE in the same state, so
  // block_q suppresses IDLE press detection until every switch is released.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      move_valid_q <= 1'b0;
      start_q      <= 1'b0;
      move_dir_q   <= C_DIR_UP;
      frog_dir_q   <= C_DIR_UP;
      block_q      <= w_Any;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      move_valid_q <= move_valid_d;
      start_q      <= start_d;
      move_dir_q   <= move_dir_d;
      frog_dir_q   <= frog_dir_d;
      block_q      <= block_d;
    end
  end

  // Next-state, repeat counter and pulse generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    move_dir_d = move_dir_q;
    frog_dir_d = frog_dir_q;
    block_d    = block_q;
    move_req   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!w_Any) begin
          block_d = 1'b0;
        end else if (!block_q) begin
          if (w_All) begin
            state_d = ST_ALL_HELD;
            start_d = 1'b1;
          end else begin
            state_d    = ST_HOLD;
            move_dir_d = w_Dir;
            frog_dir_d = w_Dir;
            move_req   = 1'b1;
          end
        end
      end

      ST_HOLD, ST_REPEAT: begin
        if (w_All) begin
          state_d = ST_ALL_HELD;
          start_d = 1'b1;
          cnt_d   = '0;
        end else if (!w_Any) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (w_Dir != move_dir_q) begin
          state_d    = ST_HOLD;
          move_dir_d = w_Dir;
          frog_dir_d = w_Dir;
          move_req   = 1'b1;
          cnt_d      = '0;
        end else if (state_q == ST_HOLD && cnt_q == DELAY_LAST) begin
          state_d  = ST_REPEAT;
          move_req = 1'b1;
          cnt_d    = '0;
        end else if (state_q == ST_REPEAT && cnt_q == PERIOD_LAST) begin
          move_req = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_ALL_HELD: begin
        cnt_d = '0;
        if (!w_All) state_d = ST_WAIT_RELEASE;
      end

      ST_WAIT_RELEASE: begin
        cnt_d = '0;
        if (!w_Any) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    move_valid_d = move_req & i_Game_Active;
  end

  assign o_Move_Valid     = move_valid_q;
  assign o_Move_Dir       = move_dir_q;
  assign o_Start          = start_q;
  assign o_Frog_Direction = frog_dir_q;

endmodule

// File: tb/tb_frog_input_sequencer.sv
// Scoreboard bench for frog_input_sequencer with short repeat timing.
module tb_frog_input_sequencer;

  localparam int unsigned DELAY  = 8;
  localparam int unsigned PERIOD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       game_active;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       start;
  logic [1:0] frog_dir;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    int         cyc;
    bit         is_start;
    logic [1:0] dir;
  } exp_t;

  exp_t sb[$];

  frog_input_sequencer #(
    .C_REPEAT_DELAY  (DELAY),
    .C_REPEAT_PERIOD (PERIOD)
  ) dut (
    .i_Clk            (clk),
    .i_Reset          (rst),
    .i_Switch_1       (sw[0]),
    .i_Switch_2       (sw[1]),
    .i_Switch_3       (sw[2]),
    .i_Switch_4       (sw[3]),
    .i_Game_Active    (game_active),
    .o_Move_Valid     (move_valid),
    .o_Move_Dir       (move_dir),
    .o_Start          (start),
    .o_Frog_Direction (frog_dir)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_move(input int c, input logic [1:0] d);
    sb.push_back('{c, 1'b0, d});
  endtask

  task automatic expect_start(input int c);
    sb.push_back('{c, 1'b1, 2'd0});
  endtask

  // Compares every observed pulse against the scoreboard and flags expected
  // pulses whose cycle has passed without being seen.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        tests_run++;
        tests_failed++;
        $display("FAIL missed_pulse: cycle %0d got no pulse, required %s dir=%0d",
                 e.cyc, e.is_start ? "start" : "move", e.dir);
      end
      if (move_valid === 1'b1 && start === 1'b1) begin
        tests_run++;
        tests_failed++;
        $display("FAIL pulse_overlap: cycle %0d got move and start together, required at most one", cyc);
      end
      if (move_valid === 1'b1 || start === 1'b1) begin
        tests_run++;
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          tests_failed++;
          $display("FAIL unexpected_pulse: cycle %0d got move=%0b start=%0b dir=%0d, required no pulse",
                   cyc, move_valid, start, move_dir);
        end else begin
          e = sb.pop_front();
          if (start !== e.is_start || move_valid !== !e.is_start ||
              (!e.is_start && move_dir !== e.dir)) begin
            tests_failed++;
            $display("FAIL pulse_content: cycle %0d got move=%0b start=%0b dir=%0d, required %s dir=%0d",
                     cyc, move_valid, start, move_dir, e.is_start ? "start" : "move", e.dir);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw = 4'b0000;
    game_active = 1'b1;
    tick(3);
    tests_run++;
    if ({move_valid, start, move_dir, frog_dir} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b start=%b dir=%b frog=%b, required all 0",
               move_valid, start, move_dir, frog_dir);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single_press();
    sw = 4'b0001;
    expect_move(cyc + 1, 2'd0);
    tick(3);
    sw = 4'b0000;
    tick(3);
    tests_run++;
    if (frog_dir !== 2'd0) begin
      tests_failed++;
      $display("FAIL single_frog_dir: got %0d, required 0", frog_dir);
    end
  endtask

  task automatic test_repeat();
    int t0;
    t0 = cyc;
    sw = 4'b0100;
    expect_move(t0 + 1, 2'd2);
    for (int k = 9; k <= 29; k += 4) expect_move(t0 + k, 2'd2);
    tick(30);
    tests_run++;
    if (frog_dir !== 2'd2) begin
      tests_failed++;
      $display("FAIL repeat_frog_dir: got %0d, required 2", frog_dir);
    end
    sw = 4'b0000;
    tick(4);
  endtask

  task automatic test_dir_change();
    int t0;
    t0 = cyc;
    sw = 4'b0010;
    expect_move(t0 + 1, 2'd1);
    tick(5);
    sw = 4'b0011;
    expect_move(t0 + 6, 2'd0);
    expect_move(t0 + 14, 2'd0);
    expect_move(t0 + 18, 2'd0);
    tick(15);
    tests_run++;
    if (frog_dir !== 2'd0 || move_dir !== 2'd0) begin
      tests_failed++;
      $display("FAIL dir_change_latch: got frog=%0d move_dir=%0d, required 0 and 0", frog_dir, move_dir);
    end
    sw = 4'b0000;
    tick(3);
  endtask

  task automatic test_all_held();
    sw = 4'b1111;
    expect_start(cyc + 1);
    tick(4);
    sw = 4'b1101;
    tick(2);
    sw = 4'b1000;
    tick(3);
    tests_run++;
    if (move_valid !== 1'b0 || start !== 1'b0) begin
      tests_failed++;
      $display("FAIL partial_release: got valid=%b start=%b, required 0 and 0", move_valid, start);
    end
    sw = 4'b0000;
    tick(1);
    sw = 4'b0001;
    expect_move(cyc + 1, 2'd0);
    tick(1);
    sw = 4'b0000;
    tick(2);
  endtask

  task automatic test_inactive();
    game_active = 1'b0;
    sw = 4'b1000;
    tick(12);
    tests_run++;
    if (frog_dir !== 2'd3) begin
      tests_failed++;
      $display("FAIL inactive_frog_dir: got %0d, required 3", frog_dir);
    end
    tests_run++;
    if (move_dir !== 2'd3) begin
      tests_failed++;
      $display("FAIL inactive_move_dir: got %0d, required 3", move_dir);
    end
    sw = 4'b0000;
    tick(2);
    game_active = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] pats [5] = '{4'b1000, 4'b1100, 4'b1010, 4'b1001, 4'b0110};
    logic [1:0] dirs [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      sw = pats[i];
      expect_move(cyc + 1, dirs[i]);
      tick(1);
      sw = 4'b0000;
      tick(1);
    end
    tick(2);
  endtask

  task automatic test_reset_mid_repeat();
    int t0;
    t0 = cyc;
    sw = 4'b0001;
    expect_move(t0 + 1, 2'd0);
    expect_move(t0 + 9, 2'd0);
    tick(11);
    rst = 1'b1;
    tick(1);
    tests_run++;
    if ({move_valid, start, move_dir, frog_dir} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_repeat: got valid=%b start=%b dir=%b frog=%b, required all 0",
               move_valid, start, move_dir, frog_dir);
    end
    rst = 1'b0;
    tick(15);
    sw = 4'b0000;
    tick(2);
    sw = 4'b0001;
    expect_move(cyc + 1, 2'd0);
    tick(2);
    sw = 4'b0000;
    tick(2);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_press();
    test_repeat();
    test_dir_change();
    test_all_held();
    test_inactive();
    test_back_to_back();
    test_reset_mid_repeat();
    tick(3);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d outstanding entries, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
